// File: rtl/pwm_deadtime.sv
// Center-aligned PWM from a triangle compare, driving a complementary
// high/low pair with dead time; duty and dead time reload at the valley.
module pwm_deadtime #(
   parameter int N = 8,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic [N-1:0] tri_in,
   input  logic [N-1:0] duty_in,
   input  logic [D-1:0] dead_in,
   input  logic         duty_wr,
   output logic         out_hi,
   output logic         out_lo,
   output logic         pending,
   output logic         period_start,
   output logic [N-1:0] duty_active
);

   typedef enum logic [1:0] {
      LO,
      DEAD_TO_HI,
      HI,
      DEAD_TO_LO
   } state_t;

   state_t       state;
   state_t       state_nx;
   logic [D-1:0] cnt;
   logic [D-1:0] cnt_nx;
   logic [D-1:0] dead_active;
   logic [D-1:0] dead_shadow;
   logic [N-1:0] duty_shadow;
   logic         raw_q;
   logic         valley;

   assign valley = ena && (tri_in == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         raw_q        <= 1'b0;
         duty_active  <= '0;
         dead_active  <= '0;
         duty_shadow  <= '0;
         dead_shadow  <= '0;
         pending      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         period_start <= valley;
         raw_q        <= tri_in < duty_active;
         if (duty_wr) begin
            duty_shadow <= duty_in;
            dead_shadow <= dead_in;
         end
         // A write coinciding with the valley bypasses the shadow.
         if (valley && duty_wr) begin
            duty_active <= duty_in;
            dead_active <= dead_in;
            pending     <= 1'b0;
         end else if (valley) begin
            if (pending) begin
               duty_active <= duty_shadow;
               dead_active <= dead_shadow;
            end
            pending <= 1'b0;
         end else if (duty_wr) begin
            pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= DEAD_TO_LO;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         LO: begin
            if (raw_q) begin
               if (dead_active == '0) begin
                  state_nx = HI;
               end else begin
                  state_nx = DEAD_TO_HI;
                  cnt_nx   = dead_active - D'(1);
               end
            end
         end
         DEAD_TO_HI: begin
            if (!raw_q)
               state_nx = LO;
            else if (cnt == '0)
               state_nx = HI;
            else
               cnt_nx = cnt - D'(1);
         end
         HI: begin
            if (!raw_q) begin
               if (dead_active == '0) begin
                  state_nx = LO;
               end else begin
                  state_nx = DEAD_TO_LO;
                  cnt_nx   = dead_active - D'(1);
               end
            end
         end
         DEAD_TO_LO: begin
            if (raw_q)
               state_nx = HI;
            else if (cnt == '0)
               state_nx = LO;
            else
               cnt_nx = cnt - D'(1);
         end
         default: ;
      endcase
   end

   assign out_hi = (state == HI);
   assign out_lo = (state == LO);

endmodule

// File: tb/tb_pwm_deadtime.sv
// Randomized and directed bench for pwm_deadtime against a
// behavioural driver/reload model.
module tb_pwm_deadtime;

   localparam int N = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         ena;
   logic [N-1:0] tri_in;
   logic [N-1:0] duty_in;
   logic [D-1:0] dead_in;
   logic         duty_wr;
   logic         out_hi;
   logic         out_lo;
   logic         pending;
   logic         period_start;
   logic [N-1:0] duty_active;

   pwm_deadtime #(.N(N), .D(D)) dut (
      .clk          (clk),
      .rst          (rst),
      .ena          (ena),
      .tri_in       (tri_in),
      .duty_in      (duty_in),
      .dead_in      (dead_in),
      .duty_wr      (duty_wr),
      .out_hi       (out_hi),
      .out_lo       (out_lo),
      .pending      (pending),
      .period_start (period_start),
      .duty_active  (duty_active)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model: side 0=low driven, 1=high driven, 2=neither (dead gap)
   int           m_out;
   int           m_to;
   int           m_left;
   bit           m_raw;
   bit           m_pend;
   bit           m_ps;
   logic [N-1:0] m_duty;
   logic [N-1:0] m_sduty;
   int           m_dead;
   int           m_sdead;

   int tv = 0;
   bit up = 1'b1;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      bit valley;
      valley = ena && (tri_in == 0);
      if (!rst) begin
         m_out   = 2;
         m_to    = 0;
         m_left  = 1;
         m_raw   = 1'b0;
         m_duty  = '0;
         m_sduty = '0;
         m_dead  = 0;
         m_sdead = 0;
         m_pend  = 1'b0;
         m_ps    = 1'b0;
      end else begin
         if (m_out == 2) begin
            if (int'(m_raw) != m_to)
               m_out = int'(m_raw);
            else if (m_left <= 1)
               m_out = m_to;
            else
               m_left--;
         end else if (int'(m_raw) != m_out) begin
            if (m_dead == 0) begin
               m_out = int'(m_raw);
            end else begin
               m_out  = 2;
               m_to   = int'(m_raw);
               m_left = m_dead;
            end
         end
         m_raw = (int'(tri_in) < int'(m_duty));
         m_ps  = valley;
         if (duty_wr) begin
            m_sduty = duty_in;
            m_sdead = int'(dead_in);
         end
         if (valley) begin
            if (duty_wr) begin
               m_duty = duty_in;
               m_dead = int'(dead_in);
            end else if (m_pend) begin
               m_duty = m_sduty;
               m_dead = m_sdead;
            end
            m_pend = 1'b0;
         end else if (duty_wr) begin
            m_pend = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      step();
      #1;
      check("out_hi", 32'(out_hi), 32'(m_out == 1));
      check("out_lo", 32'(out_lo), 32'(m_out == 0));
      check("pending", 32'(pending), 32'(m_pend));
      check("period_start", 32'(period_start), 32'(m_ps));
      check("duty_active", 32'(duty_active), 32'(m_duty));
      check("excl", 32'(out_hi & out_lo), 32'd0);
   endtask

   task automatic advance();
      if (up) begin
         if (tv == 255) begin up = 1'b0; tv = 254; end
         else tv++;
      end else begin
         if (tv == 0) begin up = 1'b1; tv = 1; end
         else tv--;
      end
   endtask

   task automatic run_tri(int n, int pct);
      for (int i = 0; i < n; i++) begin
         ena     = ($urandom_range(99) < pct);
         tri_in  = 8'(tv);
         duty_wr = 1'b0;
         tick();
         if (ena) advance();
      end
   endtask

   task automatic wr(int d, int dd, int t, bit e);
      tri_in  = 8'(t);
      ena     = e;
      duty_wr = 1'b1;
      duty_in = 8'(d);
      dead_in = 4'(dd);
      tick();
      duty_wr = 1'b0;
   endtask

   task automatic hold(int t, bit e, int n);
      tri_in  = 8'(t);
      ena     = e;
      duty_wr = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst = 1'b0; ena = 1'b0; tri_in = '0;
      duty_in = '0; dead_in = '0; duty_wr = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      hold(50, 1'b0, 3);

      // shadow load waits for the valley
      wr(128, 0, 50, 1'b1);
      check("sh_pend", 32'(pending), 32'd1);
      check("sh_duty", 32'(duty_active), 32'd0);
      hold(50, 1'b1, 3);
      check("sh_hold", 32'(duty_active), 32'd0);
      hold(0, 1'b1, 1);
      check("vl_duty", 32'(duty_active), 32'd128);
      check("vl_pend", 32'(pending), 32'd0);
      check("vl_ps", 32'(period_start), 32'd1);
      hold(1, 1'b1, 1);
      check("vl_ps_end", 32'(period_start), 32'd0);

      // dead time 3, continuous stepping
      wr(128, 3, 0, 1'b1);
      tv = 1; up = 1'b1;
      run_tri(1100, 100);

      // reset while the high side is driven
      begin
         int k;
         k = 0;
         while (!out_hi && k < 600) begin
            run_tri(1, 100);
            k++;
         end
         check("wait_hi", 32'(out_hi), 32'd1);
      end
      rst = 1'b0;
      hold(tv, 1'b1, 1);
      check("rs_hi", 32'(out_hi), 32'd0);
      check("rs_lo", 32'(out_lo), 32'd0);
      check("rs_duty", 32'(duty_active), 32'd0);
      rst = 1'b1;
      hold(200, 1'b0, 3);

      // abort: short high pulse within a long dead time
      wr(100, 5, 0, 1'b1);
      hold(200, 1'b0, 8);
      hold(10, 1'b0, 2);
      hold(200, 1'b0, 8);
      check("ab_lo", 32'(out_lo), 32'd1);

      // extremes
      wr(0, 2, 0, 1'b1);
      tv = 1; up = 1'b1;
      run_tri(600, 100);
      wr(255, 0, 0, 1'b1);
      tv = 1; up = 1'b1;
      run_tri(1100, 100);

      // write/valley collision then last-write-wins
      wr(200, 1, 30, 1'b1);
      wr(64, 2, 0, 1'b1);
      check("col_duty", 32'(duty_active), 32'd64);
      check("col_pend", 32'(pending), 32'd0);
      wr(10, 3, 30, 1'b1);
      wr(20, 4, 31, 1'b1);
      hold(0, 1'b1, 1);
      check("lww_duty", 32'(duty_active), 32'd20);
      hold(5, 1'b1, 2);

      // random soak
      tv = 0; up = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         rst     = ($urandom_range(999) >= 3);
         ena     = ($urandom_range(99) < 85);
         tri_in  = ($urandom_range(9) == 0) ? 8'($urandom) : 8'(tv);
         duty_wr = ($urandom_range(39) == 0);
         case ($urandom_range(5))
            0:       duty_in = 8'd0;
            1:       duty_in = 8'd255;
            default: duty_in = 8'($urandom);
         endcase
         dead_in = 4'($urandom_range(15));
         tick();
         if (ena) advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
